// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-buffer entry type.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [WORD_W-1:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: request handshake plus in-order response.
interface fetch_stage_if;
  import mips_pkg::*;

  logic              imem_req_valid;
  logic [WORD_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [WORD_W-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );

endinterface

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instr} returned words; clear empties it, trim keeps only the head.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       clear,
  input  logic                       trim,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never used.
  always_ff @(posedge clk) begin
    if (push && !clear && !trim) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (trim) begin
      if (count != '0) begin
        wr_ptr <= wrap_inc(rd_ptr);
        count  <= CW'(1);
      end
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC and IF/ID, issues credit-limited in-order fetches, obeys stalls/redirects.
// Optional build macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction across a redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              ir_write,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  fetch_stage_if.master     imem,
  output logic              if_id_valid,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc4
);

  localparam int             CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0]    MAX_C = MAX_OUTSTANDING[CW:0];

  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding, outstanding_next;
  logic [CW-1:0]     discard_cnt, discard_next;
  logic [CW-1:0]     occupancy;
  logic              req_fire, resp, kept, avail, take;
  logic              buf_push, buf_pop, buf_clear, buf_trim;
  fetch_entry_t      head, buf_head, resp_entry;

  assign resp       = imem.imem_resp_valid;
  assign resp_entry = '{pc: resp_pc, instr: imem.imem_resp_data};

  // Credits cover both in-flight requests and buffered words, so the buffer can never overflow.
  assign imem.imem_req_valid = rst_n & pc_write & ~redirect_valid &
                               (({1'b0, outstanding} + {1'b0, occupancy}) < MAX_C);
  assign imem.imem_req_addr  = fetch_pc;
  assign req_fire            = imem.imem_req_valid & imem.imem_req_ready;

  assign kept             = resp & (discard_cnt == '0);
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp);
  assign discard_next     = (resp && discard_cnt != '0) ? discard_cnt - 1'b1 : discard_cnt;

  // An arriving word bypasses an empty buffer straight into IF/ID.
  assign avail = (occupancy != '0) | kept;
  assign head  = (occupancy != '0) ? buf_head : resp_entry;
  assign take  = ir_write & avail;

`ifdef BRANCH_DELAY_SLOT_EN
  logic              pend_valid, jump_pending;
  logic [WORD_W-1:0] pend_pc, jump_pc;
  logic [CW-1:0]     tail_kill, live;

  assign live = outstanding_next - discard_next;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    buf_push  = kept & ~(take & (occupancy == '0));
    buf_pop   = take & (occupancy != '0);
    buf_clear = 1'b0;
    buf_trim  = 1'b0;
    if (redirect_valid) begin
`ifdef BRANCH_DELAY_SLOT_EN
      buf_pop   = 1'b0;
      buf_clear = take;
      buf_trim  = ~take & (occupancy != '0);
      buf_push  = ~take & (occupancy == '0) & kept;
`else
      buf_push  = 1'b0;
      buf_pop   = 1'b0;
      buf_clear = 1'b1;
`endif
    end
  end

  fetch_buffer #(.DEPTH(MAX_OUTSTANDING)) u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (buf_push),
    .push_entry (resp_entry),
    .pop        (buf_pop),
    .clear      (buf_clear),
    .trim       (buf_trim),
    .head       (buf_head),
    .count      (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
`else
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
`endif
    end else if (ir_write) begin
      if_id_valid <= avail;
      if_id_instr <= avail ? head.instr : NOP;
      if (avail) if_id_pc4 <= head.pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      outstanding  <= '0;
      discard_cnt  <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid   <= 1'b0;
      pend_pc      <= '0;
      jump_pending <= 1'b0;
      jump_pc      <= '0;
      tail_kill    <= '0;
`endif
    end else begin
      outstanding <= outstanding_next;
      discard_cnt <= discard_next;
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (kept)     resp_pc  <= resp_pc + 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
      if (redirect_valid) begin
        if (avail) begin
          // Delay slot is in hand: everything still in flight is wrong-path.
          fetch_pc     <= redirect_pc;
          resp_pc      <= redirect_pc;
          discard_cnt  <= outstanding_next;
          jump_pending <= 1'b0;
        end else begin
          jump_pending <= 1'b1;
          jump_pc      <= redirect_pc;
          if (live != '0) begin
            fetch_pc  <= redirect_pc;
            tail_kill <= live - 1'b1;
          end else begin
            pend_valid <= 1'b1;
            pend_pc    <= redirect_pc;
            tail_kill  <= '0;
          end
        end
      end else begin
        if (req_fire && pend_valid) begin
          fetch_pc   <= pend_pc;
          pend_valid <= 1'b0;
        end
        // The delay slot has arrived; drop the sequential words behind it and follow the target.
        if (kept && jump_pending) begin
          resp_pc      <= jump_pc;
          jump_pending <= 1'b0;
          discard_cnt  <= tail_kill;
          tail_kill    <= '0;
        end
      end
`else
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        discard_cnt <= outstanding_next;
      end
`endif
    end
  end

  resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n) resp |-> outstanding != '0)
    else $error("imem response with no request outstanding");

endmodule
